// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, decode enums and the integer ALU/immediate helpers.
// Defining RV32M_MUL_EN adds the MUL operation to the ALU.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} instr_fmt_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input instr_fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{i[31]}}, i[31:20]};
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   return {i[31:12], 12'h000};
      FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // alt selects SUB/SRA; the caller only raises it for encodings where it is legal
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
`ifdef RV32M_MUL_EN
      ALU_MUL:  return a * b;
`endif
      default:  return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_imem.sv
// Combinational instruction ROM; contents are preloaded into mem from outside.
module rv32i_imem #(
  parameter int WORDS = 1024
) (
  input  logic [29:0] word_addr,
  output logic [31:0] rdata
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] mem [WORDS];

  assign rdata = ({2'b00, word_addr} < 32'(WORDS)) ? mem[word_addr[AW-1:0]] : 32'h0;

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback each clock.
// Optional macro RV32M_MUL_EN enables MUL (funct7 0000001, funct3 000).
module rv32i_core
  import rv32i_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        CLK,
  input  logic        RST_X,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);
  localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [31:0]   regs [32];
  logic [31:0]   dmem [DMEM_WORDS];
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [4:0]    rs1, rs2;
  instr_fmt_e    fmt;
  alu_op_e       alu_op;
  logic          use_imm, rf_we, mem_we, is_load, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic          branch_taken;
  logic [31:0]   imm, rs1_val, rs2_val, alu_b, alu_res, pc_plus4, next_pc, dmem_rdata;
  logic [DW-1:0] dmem_idx;

  rv32i_imem #(.WORDS(IMEM_WORDS)) imem (
    .word_addr(pc[31:2]),
    .rdata    (instr)
  );

  assign opcode = instr[6:0];
  assign wb_rd  = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Anything not matched below leaves every enable low and so behaves as a NOP
  always_comb begin
    fmt = FMT_R; alu_op = ALU_ADD; use_imm = 1'b0; rf_we = 1'b0; mem_we = 1'b0;
    is_load = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    is_lui = 1'b0; is_auipc = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          alu_op = alu_op_from_f3(funct3, 1'b0);
          rf_we  = 1'b1;
        end else if (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)) begin
          alu_op = alu_op_from_f3(funct3, 1'b1);
          rf_we  = 1'b1;
        end
`ifdef RV32M_MUL_EN
        else if (funct7 == F7_MULDIV && funct3 == F3_MUL) begin
          alu_op = ALU_MUL;
          rf_we  = 1'b1;
        end
`endif
      end
      OPC_OP_IMM: begin
        fmt     = FMT_I;
        use_imm = 1'b1;
        alu_op  = alu_op_from_f3(funct3, funct3 == F3_SRL_SRA && funct7 == F7_ALT);
        if (funct3 == F3_SLL)          rf_we = (funct7 == F7_BASE);
        else if (funct3 == F3_SRL_SRA) rf_we = (funct7 == F7_BASE || funct7 == F7_ALT);
        else                           rf_we = 1'b1;
      end
      OPC_LOAD: begin
        fmt = FMT_I; use_imm = 1'b1;
        is_load = (funct3 == F3_LW);
        rf_we   = is_load;
      end
      OPC_STORE: begin
        fmt = FMT_S; use_imm = 1'b1;
        mem_we = (funct3 == F3_SW);
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        is_branch = (funct3 != 3'b010 && funct3 != 3'b011);
      end
      OPC_JAL:   begin fmt = FMT_J; is_jal = 1'b1; rf_we = 1'b1; end
      OPC_JALR:  begin
        fmt = FMT_I; use_imm = 1'b1;
        is_jalr = (funct3 == F3_JALR);
        rf_we   = is_jalr;
      end
      OPC_LUI:   begin fmt = FMT_U; is_lui = 1'b1; rf_we = 1'b1; end
      OPC_AUIPC: begin fmt = FMT_U; is_auipc = 1'b1; rf_we = 1'b1; end
      default: ;
    endcase
  end

  assign imm        = imm_gen(instr, fmt);
  assign rs1_val    = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val    = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
  assign alu_b      = use_imm ? imm : rs2_val;
  assign alu_res    = alu(alu_op, rs1_val, alu_b);
  assign pc_plus4   = pc + 32'd4;
  assign dmem_idx   = DW'({2'b00, alu_res[31:2]} % DMEM_WORDS);
  assign dmem_rdata = dmem[dmem_idx];

  always_comb begin
    case (funct3)
      F3_BEQ:  branch_taken = (rs1_val == rs2_val);
      F3_BNE:  branch_taken = (rs1_val != rs2_val);
      F3_BLT:  branch_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: branch_taken = (rs1_val < rs2_val);
      F3_BGEU: branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal || (is_branch && branch_taken)) next_pc = pc + imm;
    else if (is_jalr)                          next_pc = (rs1_val + imm) & ~32'd1;
  end

  always_comb begin
    if (is_load)                wb_data = dmem_rdata;
    else if (is_jal || is_jalr) wb_data = pc_plus4;
    else if (is_lui)            wb_data = imm;
    else if (is_auipc)          wb_data = pc + imm;
    else                        wb_data = alu_res;
  end

  assign wb_en = RST_X && rf_we && (wb_rd != 5'd0);

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      pc <= next_pc;
      if (wb_en) regs[wb_rd] <= wb_data;
    end
  end

  // Data memory keeps its contents across reset
  always_ff @(posedge CLK) begin
    if (RST_X && mem_we) dmem[dmem_idx] <= rs2_val;
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: hand-assembled programs with hand-computed PC and writeback values.
module tb_rv32i_core;

  localparam logic [6:0] opImm  = 7'b0010011;
  localparam logic [6:0] opLoad = 7'b0000011;
  localparam logic [6:0] opJalr = 7'b1100111;
  localparam logic [6:0] opLui  = 7'b0110111;
  localparam logic [6:0] opAuipc = 7'b0010111;

  typedef struct {
    logic [31:0] ins;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b1;
  logic [31:0] pc, instr, wb_data;
  logic        wb_en;
  logic [4:0]  wb_rd;

  int   compareCount = 0;
  int   failCount = 0;
  vec_t vecs[$];

  rv32i_core #(.IMEM_WORDS(1024), .DMEM_WORDS(1024), .RESET_PC(32'h0)) dut (
    .CLK    (CLK),
    .RST_X  (RST_X),
    .pc     (pc),
    .instr  (instr),
    .wb_en  (wb_en),
    .wb_rd  (wb_rd),
    .wb_data(wb_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] word);
    dut.imem.mem[idx] = word;
  endtask

  task automatic clearImem();
    for (int i = 0; i < 1024; i++) dut.imem.mem[i] = 32'h0;
  endtask

  task automatic stepClock();
    @(posedge CLK);
    #2;
  endtask

  task automatic addVec(input logic [31:0] ins, input logic en, input logic [4:0] rd, input logic [31:0] data);
    vec_t v;
    v.ins = ins; v.en = en; v.rd = rd; v.data = data;
    vecs.push_back(v);
  endtask

  task automatic resetCore(input string tag);
    RST_X = 1'b0;
    #1;
    checkOutput({tag, " reset pc"}, pc, 32'h0);
    checkOutput({tag, " reset wb_en"}, {31'b0, wb_en}, 32'h0);
    stepClock();
    checkOutput({tag, " reset pc held"}, pc, 32'h0);
    RST_X = 1'b1;
    #1;
  endtask

  task automatic checkWb(input string tag, input logic [31:0] expPc, input logic expEn,
                         input logic [4:0] expRd, input logic [31:0] expData);
    checkOutput({tag, " pc"}, pc, expPc);
    checkOutput({tag, " wb_en"}, {31'b0, wb_en}, {31'b0, expEn});
    if (expEn) begin
      checkOutput({tag, " wb_rd"}, {27'b0, wb_rd}, {27'b0, expRd});
      checkOutput({tag, " wb_data"}, wb_data, expData);
    end
  endtask

  task automatic runProgram(input string name);
    clearImem();
    foreach (vecs[i]) applyStimulus(i, vecs[i].ins);
    resetCore(name);
    foreach (vecs[i]) begin
      checkOutput($sformatf("%s[%0d] instr", name, i), instr, vecs[i].ins);
      checkWb($sformatf("%s[%0d]", name, i), 32'(4 * i), vecs[i].en, vecs[i].rd, vecs[i].data);
      stepClock();
    end
    checkOutput({name, " final pc"}, pc, 32'(4 * vecs.size()));
    vecs.delete();
  endtask

  initial begin
    #1;

    addVec(32'h0, 1'b0, 5'd0, 32'h0);
    addVec(encI(12'd10, 5'd0, 3'b000, 5'd5, opImm), 1'b1, 5'd5, 32'd10);
    addVec(encI(12'd32, 5'd0, 3'b000, 5'd6, opImm), 1'b1, 5'd6, 32'd32);
    addVec(encR(7'h00, 5'd6, 5'd5, 3'b000, 5'd7), 1'b1, 5'd7, 32'd42);
    runProgram("basic");

    addVec(encI(12'hFD0, 5'd0, 3'b000, 5'd5, opImm), 1'b1, 5'd5, 32'hFFFFFFD0);
    addVec(encI(12'd42, 5'd0, 3'b000, 5'd6, opImm), 1'b1, 5'd6, 32'd42);
    addVec(encR(7'h00, 5'd6, 5'd5, 3'b000, 5'd7), 1'b1, 5'd7, 32'hFFFFFFFA);
    addVec(encR(7'h20, 5'd6, 5'd5, 3'b000, 5'd8), 1'b1, 5'd8, 32'hFFFFFFA6);
    addVec(encR(7'h00, 5'd6, 5'd5, 3'b010, 5'd9), 1'b1, 5'd9, 32'd1);
    addVec(encR(7'h00, 5'd6, 5'd5, 3'b011, 5'd10), 1'b1, 5'd10, 32'd0);
    addVec(encI(12'h404, 5'd5, 3'b101, 5'd11, opImm), 1'b1, 5'd11, 32'hFFFFFFFD);
    addVec(encI(12'h01C, 5'd5, 3'b101, 5'd12, opImm), 1'b1, 5'd12, 32'h0000000F);
    addVec(encI(12'd33, 5'd0, 3'b000, 5'd16, opImm), 1'b1, 5'd16, 32'd33);
    addVec(encR(7'h00, 5'd16, 5'd6, 3'b001, 5'd15), 1'b1, 5'd15, 32'd84);
    addVec(encU(20'h12345, 5'd13, opLui), 1'b1, 5'd13, 32'h12345000);
    addVec(encU(20'h00001, 5'd14, opAuipc), 1'b1, 5'd14, 32'h0000102C);
    addVec(encI(12'd5, 5'd0, 3'b000, 5'd0, opImm), 1'b0, 5'd0, 32'h0);
    addVec(encR(7'h00, 5'd6, 5'd0, 3'b000, 5'd17), 1'b1, 5'd17, 32'd42);
`ifdef RV32M_MUL_EN
    addVec(encR(7'h01, 5'd6, 5'd5, 3'b000, 5'd18), 1'b1, 5'd18, 32'hFFFFF820);
`else
    addVec(encR(7'h01, 5'd6, 5'd5, 3'b000, 5'd18), 1'b0, 5'd0, 32'h0);
`endif
    addVec(encI(12'd0, 5'd0, 3'b000, 5'd19, opLoad), 1'b0, 5'd0, 32'h0);
    addVec(encI(12'hFFF, 5'd5, 3'b100, 5'd20, opImm), 1'b1, 5'd20, 32'h0000002F);
    addVec(encI(12'hFFF, 5'd6, 3'b011, 5'd21, opImm), 1'b1, 5'd21, 32'd1);
    addVec(encI(12'h0FF, 5'd5, 3'b111, 5'd22, opImm), 1'b1, 5'd22, 32'h000000D0);
    addVec(encR(7'h20, 5'd16, 5'd5, 3'b101, 5'd23), 1'b1, 5'd23, 32'hFFFFFFE8);
    runProgram("alu");

    addVec(encI(12'd400, 5'd0, 3'b000, 5'd2, opImm), 1'b1, 5'd2, 32'd400);
    addVec(encI(12'd5, 5'd0, 3'b000, 5'd10, opImm), 1'b1, 5'd10, 32'd5);
    addVec(encS(12'd0, 5'd10, 5'd2, 3'b010), 1'b0, 5'd0, 32'h0);
    addVec(encS(12'd0, 5'd0, 5'd2, 3'b000), 1'b0, 5'd0, 32'h0);
    addVec(encI(12'd0, 5'd2, 3'b010, 5'd11, opLoad), 1'b1, 5'd11, 32'd5);
    addVec(encU(20'h00001, 5'd13, opLui), 1'b1, 5'd13, 32'h00001000);
    addVec(encR(7'h00, 5'd2, 5'd13, 3'b000, 5'd13), 1'b1, 5'd13, 32'h00001190);
    addVec(encI(12'd0, 5'd13, 3'b010, 5'd14, opLoad), 1'b1, 5'd14, 32'd5);
    addVec(encI(12'd2, 5'd2, 3'b010, 5'd15, opLoad), 1'b1, 5'd15, 32'd5);
    addVec(encS(12'd4, 5'd13, 5'd2, 3'b010), 1'b0, 5'd0, 32'h0);
    addVec(encI(12'd4, 5'd2, 3'b010, 5'd16, opLoad), 1'b1, 5'd16, 32'h00001190);
    addVec(encI(12'hFFC, 5'd2, 3'b000, 5'd2, opImm), 1'b1, 5'd2, 32'd396);
    addVec(encI(12'd4, 5'd2, 3'b010, 5'd17, opLoad), 1'b1, 5'd17, 32'd5);
    runProgram("mem");

    clearImem();
    applyStimulus(0, encI(12'd20, 5'd0, 3'b000, 5'd6, opImm));
    applyStimulus(2, encJ(21'd228, 5'd0));
    applyStimulus(59, encI(12'd7, 5'd0, 3'b000, 5'd1, opImm));
    applyStimulus(65, encI(12'd0, 5'd6, 3'b000, 5'd5, opJalr));
    applyStimulus(5, encI(12'd3, 5'd6, 3'b000, 5'd7, opJalr));
    resetCore("jump");
    checkWb("jump addi", 32'd0, 1'b1, 5'd6, 32'd20); stepClock();
    checkWb("jump nop", 32'd4, 1'b0, 5'd0, 32'h0); stepClock();
    checkWb("jal x0", 32'd8, 1'b0, 5'd0, 32'h0); stepClock();
    checkWb("jal target", 32'd236, 1'b1, 5'd1, 32'd7); stepClock();
    for (int k = 0; k < 5; k++) stepClock();
    checkWb("jalr", 32'd260, 1'b1, 5'd5, 32'd264); stepClock();
    checkWb("jalr target", 32'd20, 1'b1, 5'd7, 32'd24); stepClock();
    checkWb("jalr lsb", 32'd22, 1'b1, 5'd7, 32'd26); stepClock();
    checkWb("jalr loop", 32'd22, 1'b1, 5'd7, 32'd26);

    clearImem();
    applyStimulus(0, encI(12'hFFF, 5'd0, 3'b000, 5'd1, opImm));
    applyStimulus(1, encI(12'd1, 5'd0, 3'b000, 5'd3, opImm));
    applyStimulus(2, encB(13'd100, 5'd3, 5'd1, 3'b110));
    applyStimulus(3, encB(13'd28, 5'd3, 5'd1, 3'b100));
    applyStimulus(10, encB(13'h1FF8, 5'd1, 5'd1, 3'b000));
    applyStimulus(8, encB(13'd12, 5'd3, 5'd1, 3'b111));
    applyStimulus(11, encB(13'd100, 5'd3, 5'd1, 3'b101));
    applyStimulus(12, encI(12'd5, 5'd0, 3'b000, 5'd0, opImm));
    resetCore("branch");
    checkWb("br x1", 32'd0, 1'b1, 5'd1, 32'hFFFFFFFF); stepClock();
    checkWb("br x3", 32'd4, 1'b1, 5'd3, 32'd1); stepClock();
    checkWb("bltu", 32'd8, 1'b0, 5'd0, 32'h0); stepClock();
    checkWb("bltu not taken", 32'd12, 1'b0, 5'd0, 32'h0); stepClock();
    checkWb("blt taken", 32'd40, 1'b0, 5'd0, 32'h0); stepClock();
    checkWb("beq back", 32'd32, 1'b0, 5'd0, 32'h0); stepClock();
    checkWb("bgeu taken", 32'd44, 1'b0, 5'd0, 32'h0); stepClock();
    checkWb("bge not taken", 32'd48, 1'b0, 5'd0, 32'h0);

    RST_X = 1'b0;
    #1;
    checkOutput("async reset pc", pc, 32'h0);
    checkOutput("async reset wb_en", {31'b0, wb_en}, 32'h0);
    checkOutput("async reset x1", dut.regs[1], 32'h0);
    checkOutput("async reset x3", dut.regs[3], 32'h0);
    stepClock();
    checkOutput("reset held pc", pc, 32'h0);
    RST_X = 1'b1;
    #1;
    checkWb("restart", 32'd0, 1'b1, 5'd1, 32'hFFFFFFFF); stepClock();
    checkWb("restart next", 32'd4, 1'b1, 5'd3, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
